// File: rtl/timeset_pkg.sv
// Shared types and elaboration helpers for the accelerating
// time-set strobe generator.
package timeset_pkg;

  localparam int LEVEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [63:0] calc_inc(
    input logic [63:0] sys_hz,
    input logic [63:0] base_hz,
    input int          level,
    input int          acc_w
  );
    return ((base_hz << level) << acc_w) / sys_hz;
  endfunction

endpackage

// File: rtl/timeset_accel_divider_frac_accum.sv
// Fractional phase accumulator; the wrap carry is registered so it
// lines up with the strobe cycle.
module frac_accum #(
  parameter int ACC_W = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_add,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_carry
);

  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_add) begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_carry <= w_sum[ACC_W];
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/timeset_accel_divider.sv
// Hold-to-accelerate time-set strobe: immediate strobe on press, then
// auto-repeat whose rate doubles every STEPS_PER_LEVEL strobes.
module timeset_accel_divider
  import timeset_pkg::*;
#(
  parameter int SYS_CLK_HZ      = 50_000_000,
  parameter int BASE_HZ         = 2,
  parameter int NUM_LEVELS      = 4,
  parameter int STEPS_PER_LEVEL = 8,
  parameter int ACC_W           = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_fast_set,
  output logic               o_timeset_stb,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int STEP_W =
    (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;
  localparam logic [STEP_W-1:0] STEP_TOP =
    STEP_W'(STEPS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP =
    LEVEL_W'(NUM_LEVELS - 1);

  localparam logic [63:0] INC_LO = calc_inc(
    64'(SYS_CLK_HZ), 64'(BASE_HZ), 0, ACC_W);
  localparam logic [63:0] INC_HI = calc_inc(
    64'(SYS_CLK_HZ), 64'(BASE_HZ), NUM_LEVELS - 1, ACC_W);

  if (NUM_LEVELS < 1 || NUM_LEVELS > 8) begin : g_bad_lvl
    $error("NUM_LEVELS must be 1..8");
  end
  if (STEPS_PER_LEVEL < 1) begin : g_bad_steps
    $error("STEPS_PER_LEVEL must be at least 1");
  end
  if (INC_LO == 64'd0 || INC_HI >= (64'd1 << ACC_W)) begin : g_bad_inc
    $error("phase increment out of range for ACC_W");
  end

  logic [ACC_W-1:0] w_inc_tbl [2**LEVEL_W];

  for (genvar g = 0; g < 2**LEVEL_W; g++) begin : g_inc
    if (g < NUM_LEVELS) begin : g_on
      localparam logic [63:0] INC_G = calc_inc(
        64'(SYS_CLK_HZ), 64'(BASE_HZ), g, ACC_W);
      assign w_inc_tbl[g] = INC_G[ACC_W-1:0];
    end else begin : g_off
      assign w_inc_tbl[g] = '0;
    end
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start;
  logic               w_add;
  logic               w_clr;
  logic               r_first;
  logic               w_carry;
  logic [STEP_W-1:0]  r_step;
  logic [STEP_W-1:0]  w_step;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level;
  logic [LEVEL_W-1:0] w_eff;
  logic               w_step_top;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (i_en)  w_state_nxt = RUN;
      RUN:  if (!i_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_add   = 1'b0;
    w_clr   = 1'b1;
    unique case (r_state)
      IDLE: w_start = i_en;
      RUN: begin
        w_add = i_en;
        w_clr = !i_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_first <= 1'b0;
    else         r_first <= w_start;
  end

  frac_accum #(
    .ACC_W(ACC_W)
  ) u_accum (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (w_clr),
    .i_add  (w_add),
    .i_inc  (w_inc_tbl[w_eff]),
    .o_carry(w_carry)
  );

  // Counters advance combinationally in the strobe cycle so the new
  // level already drives this cycle's add and o_level.
  assign w_step_top = (r_step == STEP_TOP);

  assign w_level =
    (w_carry && w_step_top && r_level != LVL_TOP)
      ? r_level + LEVEL_W'(1) : r_level;

  assign w_step =
    !w_carry   ? r_step :
    w_step_top ? '0     : r_step + STEP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_clr) begin
      r_step  <= '0;
      r_level <= '0;
    end else begin
      r_step  <= w_step;
      r_level <= w_level;
    end
  end

  assign w_eff         = i_fast_set ? LVL_TOP : w_level;
  assign o_level       = w_eff;
  assign o_timeset_stb = r_first | (w_carry & i_en);

endmodule

// File: tb/tb_timeset_accel_divider.sv
// Randomized and directed bench for timeset_accel_divider against a
// per-cycle arithmetic model of the accelerating repeat rules.
module tb_timeset_accel_divider;

  localparam int SYS = 1024;
  localparam int BASE = 16;
  localparam int AW = 10;
  localparam int NL = 4;
  localparam int SPL = 3;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_en;
  logic       i_fast_set;
  logic       o_stb;
  logic [2:0] o_level;

  always #5 clk = ~clk;

  timeset_accel_divider #(
    .SYS_CLK_HZ(SYS),
    .BASE_HZ(BASE),
    .NUM_LEVELS(NL),
    .STEPS_PER_LEVEL(SPL),
    .ACC_W(AW)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_en(i_en),
    .i_fast_set(i_fast_set),
    .o_timeset_stb(o_stb),
    .o_level(o_level)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit m_run, m_first, m_carry;
  int m_acc, m_step, m_lvl;
  int cyc_n;
  int prev_stb;
  int last_stb, last_lvl;
  int stb_log[$];

  function automatic int inc_of(input int k);
    return ((BASE << k) * (1 << AW)) / SYS;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit fs);
    int eff;
    m_first = 0;
    m_carry = 0;
    if (rst || (m_run && !en)) begin
      m_run = 0;
      m_acc = 0; m_step = 0; m_lvl = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_first = 1;
        m_acc = 0; m_step = 0; m_lvl = 0;
      end
    end else begin
      eff = fs ? NL - 1 : m_lvl;
      m_acc += inc_of(eff);
      if (m_acc >= (1 << AW)) begin
        m_acc -= (1 << AW);
        m_carry = 1;
        if (m_step == SPL - 1) begin
          m_step = 0;
          if (m_lvl < NL - 1) m_lvl++;
        end else begin
          m_step++;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit fs);
    int es, el;
    @(negedge clk);
    i_reset = rst; i_en = en; i_fast_set = fs;
    #1;
    es = (m_first || (m_carry && en)) ? 1 : 0;
    el = fs ? NL - 1 : m_lvl;
    chk("stb", int'(o_stb), es);
    chk("level", int'(o_level), el);
    chk("back2back", int'(o_stb) & prev_stb, 0);
    prev_stb = int'(o_stb);
    last_stb = int'(o_stb);
    last_lvl = int'(o_level);
    if (o_stb) stb_log.push_back(cyc_n);
    cyc_n++;
    @(posedge clk);
    model_step(rst, en, fs);
  endtask

  task automatic log_start();
    stb_log.delete();
    cyc_n = 0;
  endtask

  int exp_t[$];
  int e;
  int n;
  bit en_r, fs_r, rst_r;

  initial begin
    m_run = 0; m_first = 0; m_carry = 0;
    m_acc = 0; m_step = 0; m_lvl = 0;
    prev_stb = 0; cyc_n = 0;
    i_reset = 1; i_en = 1; i_fast_set = 0;
    @(posedge clk);
    model_step(1, 1, 0);

    // reset held with button pressed
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);

    // long hold: acceleration through all levels
    log_start();
    for (int i = 0; i < 400; i++) cyc(0, 1, 0);
    e = 1;
    exp_t.push_back(e);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 3; r++) begin
        e += 64 >> k;
        exp_t.push_back(e);
      end
    while (e + 8 < 400) begin
      e += 8;
      exp_t.push_back(e);
    end
    chk("t2_count", stb_log.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < stb_log.size(); i++)
      chk("t2_time", stb_log[i], exp_t[i]);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);

    // fast-set forced top rate, then released
    log_start();
    for (int i = 0; i < 40; i++) cyc(0, 1, 1);
    for (int i = 0; i < 150; i++) cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) chk("t3_fast", stb_log[i], 1 + 8 * i);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);

    // release on the strobe cycle
    n = 0;
    cyc(0, 1, 0);
    while (!m_carry && n < 500) begin
      cyc(0, 1, 0);
      n++;
    end
    chk("t4_carry_seen", int'(m_carry), 1);
    cyc(0, 0, 0);
    chk("t4_supp", last_stb, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("t4_repress", last_stb, 1);
    chk("t4_lvl", last_lvl, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);

    // single-cycle press
    log_start();
    cyc(0, 1, 0);
    for (int i = 0; i < 201; i++) cyc(0, 0, 0);
    chk("t5_count", stb_log.size(), 1);

    // reset at level 2 while held
    n = 0;
    cyc(0, 1, 0);
    while (m_lvl != 2 && n < 600) begin
      cyc(0, 1, 0);
      n++;
    end
    chk("t6_lvl2", m_lvl, 2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    log_start();
    cyc(0, 1, 0);
    chk("t6_nostb", last_stb, 0);
    chk("t6_lvl0", last_lvl, 0);
    for (int i = 0; i < 140; i++) cyc(0, 1, 0);
    chk("t6_cnt", stb_log.size(), 3);
    for (int i = 0; i < 3 && i < stb_log.size(); i++)
      chk("t6_time", stb_log[i], 1 + 64 * i);

    // random holds, fast-set toggles and occasional reset
    en_r = 0; fs_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) en_r = !en_r;
      if ($urandom_range(59) == 0) fs_r = !fs_r;
      rst_r = ($urandom_range(299) == 0);
      cyc(rst_r, en_r, fs_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
